// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//   Bundle of the opcode/memory-handshake inputs and the datapath control
//   outputs of the multicycle MIPS main control FSM.
//
//   master modport : the control FSM (consumes opcode_i/memReady_i, drives
//                    all datapath selects, enables and status flags)
//   slave modport  : the datapath / environment side (the mirror image)
//
//   Signals:
//     opcode_i       IR[31:26], only meaningful in DECODE
//     memReady_i     memory access completes this cycle
//     pcWrite_o      unconditional PC write
//     pcWriteCond_o  PC write if ALU zero
//     pcSrc_o        00 ALU, 01 ALUOut, 10 jump target
//     iorD_o         0 PC address, 1 ALUOut address
//     memRead_o      memory read request
//     memWrite_o     memory write request
//     irWrite_o      IR load enable
//     memToReg_o     1 write-back from MDR
//     regDst_o       1 rd, 0 rt
//     regWrite_o     register file write enable
//     aluSrcA_o      0 PC, 1 rs
//     aluSrcB_o      00 rt, 01 const 4, 10 signext imm, 11 imm<<2
//     aluOp_o        ALU control class (00 add, 01 sub, 10 funct)
//     state_o        current state code (debug)
//     illegal_o      sticky illegal-opcode trap flag
//     timeout_o      sticky memory-timeout trap flag
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
) ();

  logic [OP_W-1:0]    opcode_i;
  logic               memReady_i;
  logic               pcWrite_o;
  logic               pcWriteCond_o;
  logic [1:0]         pcSrc_o;
  logic               iorD_o;
  logic               memRead_o;
  logic               memWrite_o;
  logic               irWrite_o;
  logic               memToReg_o;
  logic               regDst_o;
  logic               regWrite_o;
  logic               aluSrcA_o;
  logic [1:0]         aluSrcB_o;
  logic [ALUOP_W-1:0] aluOp_o;
  logic [3:0]         state_o;
  logic               illegal_o;
  logic               timeout_o;

  modport master (
    input  opcode_i, memReady_i,
    output pcWrite_o, pcWriteCond_o, pcSrc_o, iorD_o, memRead_o, memWrite_o,
           irWrite_o, memToReg_o, regDst_o, regWrite_o, aluSrcA_o, aluSrcB_o,
           aluOp_o, state_o, illegal_o, timeout_o
  );

  modport slave (
    output opcode_i, memReady_i,
    input  pcWrite_o, pcWriteCond_o, pcSrc_o, iorD_o, memRead_o, memWrite_o,
           irWrite_o, memToReg_o, regDst_o, regWrite_o, aluSrcA_o, aluSrcB_o,
           aluOp_o, state_o, illegal_o, timeout_o
  );

endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Multicycle MIPS main control FSM. Steps FETCH/DECODE/EXEC/MEM/WB one state
//   per clock, drives the shared-memory, IR, PC and ALU datapath selects,
//   stalls on memory ready and traps on illegal opcodes or memory timeout.
//
//   Ports:
//     clk_i   rising-edge clock
//     rst_i   synchronous, active-high reset
//     bus     multicycle_control_if.master (opcode/memReady in, controls out)
//
//   Configuration macro:
//     MC_JUMP_EN  when defined, OP_J decodes to the JUMP state (pcWrite=1,
//                 pcSrc=10); when undefined OP_J is trapped as illegal.
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int              OP_W     = 6,
  parameter int              ALUOP_W  = 2,
  parameter logic [OP_W-1:0] OP_RTYPE = 6'h00,
  parameter logic [OP_W-1:0] OP_LW    = 6'h23,
  parameter logic [OP_W-1:0] OP_SW    = 6'h2B,
  parameter logic [OP_W-1:0] OP_BEQ   = 6'h04,
  parameter logic [OP_W-1:0] OP_J     = 6'h02,
  parameter int              TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  multicycle_control_if.master bus
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd15
  } state_e;

  // Registered per-state control word. 'fetch' marks FETCH so that the
  // IR/PC load enables can be qualified by memReady_i at the output.
  typedef struct packed {
    logic               fetch;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_src;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'b01;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
`endif
      default: ;  // TRAP and unused codes: every control stays 0
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_lw_q, is_lw_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             mem_wait;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = '0;
    is_lw_d   = is_lw_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    case (state_q)
      S_FETCH:  if (bus.memReady_i) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode_i)
          OP_RTYPE: state_d = S_EXEC;
          OP_LW: begin
            state_d = S_MEMADR;
            is_lw_d = 1'b1;
          end
          OP_SW: begin
            state_d = S_MEMADR;
            is_lw_d = 1'b0;
          end
          OP_BEQ:   state_d = S_BRANCH;
`ifdef MC_JUMP_EN
          OP_J:     state_d = S_JUMP;
`endif
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      // The LW/SW split uses the class latched in DECODE, not the live opcode.
      S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.memReady_i) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (bus.memReady_i) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
`ifdef MC_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase

    // Wait counter: only advances while a memory state is stalled; any other
    // cycle (including the ready cycle and every state entry) leaves it at 0.
    // A ready on the last allowed cycle skips this block and wins.
    if (mem_wait && !bus.memReady_i) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = S_TRAP;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    ctrl_d = decode(state_d);
  end

  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      is_lw_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      ctrl_q    <= decode(S_FETCH);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_lw_q   <= is_lw_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // IR load and PC increment in FETCH happen only on the cycle the read lands.
  assign bus.irWrite_o     = ctrl_q.fetch & bus.memReady_i;
  assign bus.pcWrite_o     = (ctrl_q.fetch & bus.memReady_i) | ctrl_q.pc_write;
  assign bus.pcWriteCond_o = ctrl_q.pc_write_cond;
  assign bus.pcSrc_o       = ctrl_q.pc_src;
  assign bus.iorD_o        = ctrl_q.iord;
  assign bus.memRead_o     = ctrl_q.mem_read;
  assign bus.memWrite_o    = ctrl_q.mem_write;
  assign bus.memToReg_o    = ctrl_q.mem_to_reg;
  assign bus.regDst_o      = ctrl_q.reg_dst;
  assign bus.regWrite_o    = ctrl_q.reg_write;
  assign bus.aluSrcA_o     = ctrl_q.alu_src_a;
  assign bus.aluSrcB_o     = ctrl_q.alu_src_b;
  assign bus.aluOp_o       = ctrl_q.alu_op;
  assign bus.state_o       = state_q;
  assign bus.illegal_o     = illegal_q;
  assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. Each scenario describes an
//   instruction abstractly (class, fetch stall, memory stall); a reference
//   model expands that into the per-cycle state/ready plan, and every cycle
//   the full output vector is compared with the table of per-state controls.
//   Honours MC_JUMP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int TIMEOUT = 16;

  logic clk_i;
  logic rst_i;

  multicycle_control_if bus_if ();

  multicycle_control dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_e;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       ill;
    logic       to;
  } step_t;

  step_t plan[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  m_ill, m_to;
  bit    m_trap;

  // ---------------- reference model ----------------
  function automatic logic [21:0] exp_vec(input step_t s);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] pcsrc, asb, aop;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
    pcsrc = 2'b00; asb = 2'b00; aop = 2'b00;
    case (s.st)
      4'd0: begin mr = 1; asb = 2'b01; irw = s.rdy; pcw = s.rdy; end
      4'd1: asb = 2'b11;
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mr = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mw = 1; iord = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      4'd9: begin pcw = 1; pcsrc = 2'b10; end
      default: ;
    endcase
    return {s.st, pcw, pcwc, pcsrc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, s.ill, s.to};
  endfunction

  function automatic logic [21:0] act_vec();
    return {bus_if.state_o, bus_if.pcWrite_o, bus_if.pcWriteCond_o, bus_if.pcSrc_o,
            bus_if.iorD_o, bus_if.memRead_o, bus_if.memWrite_o, bus_if.irWrite_o,
            bus_if.memToReg_o, bus_if.regDst_o, bus_if.regWrite_o, bus_if.aluSrcA_o,
            bus_if.aluSrcB_o, bus_if.aluOp_o, bus_if.illegal_o, bus_if.timeout_o};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy);
    step_t s;
    s.st = st; s.rdy = rdy; s.ill = m_ill; s.to = m_to;
    plan.push_back(s);
  endtask

  task automatic trap_hold();
    m_trap = 1'b1;
    repeat (4) push(4'd15, 1'($urandom));
  endtask

  // A memory-waiting state stalls 'delay' cycles; beyond TIMEOUT cycles of
  // stall the FSM traps instead of completing.
  task automatic wait_phase(input logic [3:0] st, input int delay);
    int n;
    n = (delay < TIMEOUT) ? delay : TIMEOUT;
    for (int i = 0; i < n; i++) push(st, 1'b0);
    if (delay >= TIMEOUT) begin
      m_to = 1'b1;
      trap_hold();
    end else begin
      push(st, 1'b1);
    end
  endtask

  task automatic build(input kind_e k, input int fd, input int md);
    wait_phase(4'd0, fd);
    if (m_trap) return;
    push(4'd1, 1'($urandom));
    case (k)
      K_R:   begin push(4'd6, 1'($urandom)); push(4'd7, 1'($urandom)); end
      K_LW:  begin
        push(4'd2, 1'($urandom));
        wait_phase(4'd3, md);
        if (!m_trap) push(4'd4, 1'($urandom));
      end
      K_SW:  begin push(4'd2, 1'($urandom)); wait_phase(4'd5, md); end
      K_BEQ: push(4'd8, 1'($urandom));
`ifdef MC_JUMP_EN
      K_J:   push(4'd9, 1'($urandom));
`else
      K_J:   begin m_ill = 1'b1; trap_hold(); end
`endif
      default: begin m_ill = 1'b1; trap_hold(); end
    endcase
  endtask

  function automatic logic [5:0] op_of(input kind_e k);
    logic [5:0] op;
    case (k)
      K_R:   op = 6'h00;
      K_LW:  op = 6'h23;
      K_SW:  op = 6'h2B;
      K_BEQ: op = 6'h04;
      K_J:   op = 6'h02;
      default: begin
        op = 6'($urandom);
        while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02)
          op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  // Drive the plan one cycle at a time; limit < 0 runs it all.
  task automatic exec_plan(input string name, input logic [5:0] op, input int limit);
    int n;
    logic [21:0] e, a;
    n = (limit < 0 || limit > plan.size()) ? plan.size() : limit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      bus_if.opcode_i   = (plan[i].st == 4'd1) ? op : 6'($urandom);
      bus_if.memReady_i = plan[i].rdy;
      #1;
      e = exp_vec(plan[i]);
      a = act_vec();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h (state %0d) expected %h (state %0d)",
                 name, i, a, a[21:18], e, e[21:18]);
      end
    end
    plan.delete();
  endtask

  task automatic run(input string name, input kind_e k, input int fd, input int md);
    logic [5:0] op;
    op = op_of(k);
    build(k, fd, md);
    exec_plan(name, op, -1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [21:0] e;
    step_t s;
    @(negedge clk_i);
    rst_i = 1'b1;
    bus_if.memReady_i = 1'($urandom);
    bus_if.opcode_i   = 6'($urandom);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    bus_if.memReady_i = 1'b0;
    m_ill = 1'b0; m_to = 1'b0; m_trap = 1'b0;
    #1;
    s.st = 4'd0; s.rdy = 1'b0; s.ill = 1'b0; s.to = 1'b0;
    e = exp_vec(s);
    n_tests++;
    if (act_vec() !== e) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", act_vec(), e);
    end
  endtask

  task automatic test_rtype();     run("rtype", K_R, 0, 0); run("rtype_fstall", K_R, 2, 0); endtask
  task automatic test_lw();        run("lw_delay2", K_LW, 0, 2); endtask
  task automatic test_sw();        run("sw", K_SW, 0, 0); run("sw_delay3", K_SW, 1, 3); endtask
  task automatic test_beq();       run("beq", K_BEQ, 0, 0); endtask
  task automatic test_ready_last(); run("sw_ready_16th", K_SW, 0, TIMEOUT - 1); endtask

  task automatic test_illegal();
    build(K_ILL, 0, 0);
    exec_plan("illegal_3f", 6'h3F, -1);
    test_reset();
  endtask

  task automatic test_timeout();
    run("sw_timeout", K_SW, 0, TIMEOUT);
    test_reset();
    run("lw_timeout", K_LW, 0, TIMEOUT + 3);
    test_reset();
  endtask

  task automatic test_jump();
    run("jump", K_J, 0, 0);
    if (m_trap) test_reset();
  endtask

  task automatic test_reset_abort();
    build(K_LW, 0, 6);
    exec_plan("abort_lw", 6'h23, 5);
    test_reset();
    build(K_SW, 0, 6);
    exec_plan("abort_sw", 6'h2B, 5);
    test_reset();
  endtask

  task automatic test_random();
    kind_e k;
    for (int i = 0; i < 40; i++) begin
      k = kind_e'($urandom_range(0, 5));
      run("random", k, $urandom_range(0, 3), $urandom_range(0, 20));
      if (m_trap) test_reset();
    end
  endtask

  initial begin
    rst_i = 1'b0;
    bus_if.opcode_i   = '0;
    bus_if.memReady_i = 1'b0;
    m_ill = 1'b0; m_to = 1'b0; m_trap = 1'b0;
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_beq();
    test_ready_last();
    test_illegal();
    test_timeout();
    test_jump();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
